// File: rtl/ttt_pkg.sv
// ============================================================================
// Module      : ttt_pkg
// Description : Shared grid constants, types and cell/row/column helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ttt_pkg;

   localparam int GRID_N  = 3;
   localparam int CELLS   = 9;
   localparam int NUM_BTN = 5;

   typedef logic [3:0] cell_t;
   typedef logic [1:0] rc_t;

   typedef enum logic [2:0] {
      UP     = 3'd0,
      DOWN   = 3'd1,
      LEFT   = 3'd2,
      RIGHT  = 3'd3,
      CENTER = 3'd4
   } btn_e;

   typedef enum logic [0:0] {
      PLAY = 1'b0,
      FULL = 1'b1
   } state_e;

   // Row from compares rather than a divider; only valid for cells 0..8.
   function automatic rc_t cell_row(cell_t c);
      if (c >= cell_t'(2 * GRID_N))
         return 2'd2;
      else if (c >= cell_t'(GRID_N))
         return 2'd1;
      return 2'd0;
   endfunction

   function automatic rc_t cell_col(cell_t c);
      cell_t t;
      t = c - (cell_t'(cell_row(c)) * cell_t'(GRID_N));
      return t[1:0];
   endfunction

   function automatic cell_t rc_to_cell(rc_t r, rc_t c);
      return (cell_t'(r) * cell_t'(GRID_N)) + cell_t'(c);
   endfunction

endpackage

`default_nettype wire

// File: rtl/ttt_cursor_ctrl_if.sv
// ============================================================================
// Module      : ttt_cursor_ctrl_if
// Description : Button inputs and frame-aligned cursor/board outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ttt_cursor_ctrl_if;
   import ttt_pkg::*;

   logic             btn_up;
   logic             btn_down;
   logic             btn_left;
   logic             btn_right;
   logic             btn_center;
   logic             clear;
   logic             frame_start;
   logic [CELLS-1:0] cell_select_flag;
   logic [CELLS-1:0] sw;
   logic             place_pulse;
   logic             board_full;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_center,
      output clear, frame_start,
      input  cell_select_flag, sw, place_pulse, board_full
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_center,
      input  clear, frame_start,
      output cell_select_flag, sw, place_pulse, board_full
   );

endinterface

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : 2-FF synchronizer, stability debounce and rising-edge press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  wire  clk,
   input  wire  reset,
   input  wire  btn_raw,
   output logic press
);

   localparam logic [CNT_W-1:0] c_last = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_level_q;
   logic             r_armed;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;

   // Synchronizer resets high so a button held through reset is not armed
   // until it has been seen released.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_level   <= 1'b0;
         r_level_q <= 1'b0;
         r_armed   <= 1'b0;
         r_cnt     <= '0;
         r_press   <= 1'b0;
      end else begin
         r_sync1   <= btn_raw;
         r_sync2   <= r_sync1;
         r_level_q <= r_level;
         r_press   <= r_level & ~r_level_q & r_armed;
         if (!r_sync2)
            r_armed <= 1'b1;
         if (r_sync2 != r_level) begin
            if (r_cnt == c_last) begin
               r_level <= r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + CNT_W'(1);
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/ttt_cursor_ctrl.sv
// ============================================================================
// Module      : ttt_cursor_ctrl
// Description : Buttons to frame-aligned cursor and occupied-cell map.
//               Define CURSOR_WRAP_EN for wrapping moves (default: clamp).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ttt_cursor_ctrl
   import ttt_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20,
   parameter int START_CELL      = 4
) (
   input  wire              clk,
   input  wire              reset,
   ttt_cursor_ctrl_if.slave bus
);

   localparam cell_t            c_start      = cell_t'(START_CELL);
   localparam logic [CELLS-1:0] c_one        = CELLS'(1);
   localparam logic [CELLS-1:0] c_start_flag = c_one << START_CELL;

   logic [NUM_BTN-1:0] w_raw;
   logic [NUM_BTN-1:0] w_press;

   state_e             r_state;
   cell_t              r_cur;
   logic [CELLS-1:0]   r_occ;
   logic               r_place_pulse;
   logic [CELLS-1:0]   r_csf;
   logic [CELLS-1:0]   r_sw;

   assign w_raw = {bus.btn_center, bus.btn_right, bus.btn_left,
                   bus.btn_down, bus.btn_up};

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce (
         .clk     (clk),
         .reset   (reset),
         .btn_raw (w_raw[g]),
         .press   (w_press[g])
      );
   end

   function automatic cell_t move_cell(cell_t c, btn_e dir);
      rc_t r;
      rc_t k;
      r = cell_row(c);
      k = cell_col(c);
      case (dir)
`ifdef CURSOR_WRAP_EN
         UP:      r = (r == 2'd0) ? 2'd2 : r - 2'd1;
         DOWN:    r = (r == 2'd2) ? 2'd0 : r + 2'd1;
         LEFT:    k = (k == 2'd0) ? 2'd2 : k - 2'd1;
         RIGHT:   k = (k == 2'd2) ? 2'd0 : k + 2'd1;
`else
         UP:      if (r != 2'd0) r = r - 2'd1;
         DOWN:    if (r != 2'd2) r = r + 2'd1;
         LEFT:    if (k != 2'd0) k = k - 2'd1;
         RIGHT:   if (k != 2'd2) k = k + 2'd1;
`endif
         default: ;
      endcase
      return rc_to_cell(r, k);
   endfunction

   // Events are served one per cycle in priority order; lower ones are dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= PLAY;
         r_cur         <= c_start;
         r_occ         <= '0;
         r_place_pulse <= 1'b0;
         r_csf         <= c_start_flag;
         r_sw          <= '0;
      end else begin
         r_place_pulse <= 1'b0;
         if (bus.clear) begin
            r_occ   <= '0;
            r_state <= PLAY;
         end else begin
            if (w_press[CENTER]) begin
               if (r_state == PLAY && !r_occ[r_cur]) begin
                  r_occ[r_cur]  <= 1'b1;
                  r_place_pulse <= 1'b1;
               end
            end else if (w_press[UP]) begin
               r_cur <= move_cell(r_cur, UP);
            end else if (w_press[DOWN]) begin
               r_cur <= move_cell(r_cur, DOWN);
            end else if (w_press[LEFT]) begin
               r_cur <= move_cell(r_cur, LEFT);
            end else if (w_press[RIGHT]) begin
               r_cur <= move_cell(r_cur, RIGHT);
            end

            case (r_state)
               PLAY:    if (&r_occ) r_state <= FULL;
               FULL:    ;
               default: r_state <= PLAY;
            endcase
         end

         // Sample pre-update state so same-cycle changes wait a frame.
         if (bus.frame_start) begin
            r_csf <= c_one << r_cur;
            r_sw  <= r_occ;
         end
      end
   end

   assign bus.cell_select_flag = r_csf;
   assign bus.sw               = r_sw;
   assign bus.place_pulse      = r_place_pulse;
   assign bus.board_full       = &r_occ;

endmodule

`default_nettype wire
